// File: rtl/hazard_scoreboard.sv
// Per-register pending-write countdown that stalls the ID-stage instruction until its sources
// can be forwarded. Defining HAZARD_PERF_EN adds a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 3,
  parameter int CNT_W      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_use_rs,
  input  logic                  i_id_use_rt,
  input  logic                  i_id_early_use,
  input  logic                  i_id_write_en,
  input  logic [REG_ADDR_W-1:0] i_id_rdest,
  input  logic [CNT_W-1:0]      i_id_latency,
  input  logic                  i_flush_id,
  output logic                  o_stall_pc,
  output logic                  o_stall_id,
  output logic                  o_stall_id_ex,
  output logic [31:0]           o_stall_count
);

  localparam logic [CNT_W-1:0]    LP_MAX_LAT  = CNT_W'(MAX_LAT);
  localparam logic [REG_ADDR_W:0] LP_NUM_REGS = (REG_ADDR_W+1)'(NUM_REGS);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_rs_cnt;
  logic [CNT_W-1:0] w_rt_cnt;
  logic [CNT_W-1:0] w_slack;
  logic [CNT_W-1:0] w_new_cnt;
  logic             w_live;
  logic             w_hazard;
  logic             w_issue;

  // Register 0 and indices beyond the implemented file always read as ready.
  always_comb begin
    w_rs_cnt = '0;
    w_rt_cnt = '0;
    if (i_id_rs != '0 && {1'b0, i_id_rs} < LP_NUM_REGS) w_rs_cnt = r_cnt[i_id_rs];
    if (i_id_rt != '0 && {1'b0, i_id_rt} < LP_NUM_REGS) w_rt_cnt = r_cnt[i_id_rt];
  end

  assign w_slack   = i_id_early_use ? '0 : CNT_W'(1);
  assign w_new_cnt = (i_id_latency > LP_MAX_LAT) ? LP_MAX_LAT : i_id_latency;
  assign w_live    = i_id_valid & ~i_flush_id;
  assign w_hazard  = w_live & ((i_id_use_rs & (w_rs_cnt > w_slack)) |
                               (i_id_use_rt & (w_rt_cnt > w_slack)));
  assign w_issue   = w_live & ~w_hazard;

  assign o_stall_pc    = w_hazard;
  assign o_stall_id    = w_hazard;
  assign o_stall_id_ex = w_hazard;

  // A new issue replaces any older countdown on the same register (WAW), even a larger one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_issue && i_id_write_en && r != 0 && i_id_rdest == REG_ADDR_W'(r))
          r_cnt[r] <= w_new_cnt;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stall_count <= '0;
    else if (w_hazard && r_stall_count != 32'hFFFF_FFFF)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign o_stall_count = r_stall_count;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised hazard unit for the 5-stage MIPS pipeline, replacing per-case stage-comparison stall logic with a per-register pending-write scoreboard.
- Each architectural register holds a countdown of cycles until its in-flight result reaches the forwarding network.
- The ID-stage instruction is stalled while any source it reads is still pending beyond the slack its consumer stage allows.
- Sits beside the ID stage; drives the PC, IF/ID and ID/EX stall/bubble controls.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers (register 0 hard-wired zero).
- REG_ADDR_W, 5, register index width; NUM_REGS <= 2**REG_ADDR_W.
- MAX_LAT, 3, largest producer latency accepted.
- CNT_W, 2, countdown width; must satisfy 2**CNT_W > MAX_LAT.

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ID_Valid  in  1  ID holds a real instruction.
- ID_rs, ID_rt  in  REG_ADDR_W each  source indices.
- ID_UseRs, ID_UseRt  in  1 each  source actually read.
- ID_EarlyUse  in  1  operands consumed in ID (branch/jr); else consumed in EX.
- ID_WriteEn  in  1  instruction writes a register.
- ID_rDest  in  REG_ADDR_W  destination index (already rt/rd/31 selected).
- ID_Latency  in  CNT_W  producer latency: ALU/mul-low = 1, lw = 2, multi-cycle = 3.
- Flush_ID  in  1  ID instruction squashed (taken branch/jump).
- Stall_PC, Stall_ID  out  1 each  hold PC / IF-ID register.
- Stall_ID_EX  out  1  insert bubble into ID/EX.
- Stall_Count  out  32  stall-cycle counter (only with HAZARD_PERF_EN).

## Operation
- State: cnt[r], CNT_W bits, for r = 1..NUM_REGS-1; cnt[0] is constant 0.
- Slack = ID_EarlyUse ? 0 : 1.
- hazard = ID_Valid & !Flush_ID & ((ID_UseRs & cnt[ID_rs] > Slack) | (ID_UseRt & cnt[ID_rt] > Slack)).
- Index 0 never hazards. Indices >= NUM_REGS read as 0.
- Stall_PC = Stall_ID = Stall_ID_EX = hazard; all three are always equal.
- issue = ID_Valid & !Flush_ID & !hazard.
- Each rising edge, for every r:
  - If issue & ID_WriteEn & ID_rDest == r & r != 0: cnt[r] <= min(ID_Latency, MAX_LAT). Issue overrides the decrement.
  - Else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - Else: hold at 0.
- Latency 0 on issue leaves the register ready immediately.
- Write-after-write: a newer issue overwrites the older countdown, even with a smaller value.
- An instruction may read and write the same register. The hazard check uses the pre-issue count; the write takes effect at the edge.
- Flush_ID: the instruction neither stalls nor issues, and the scoreboard only decrements. Flush has priority over hazard.
- Resulting behaviour:
  - lw -> dependent EX consumer: 1 bubble.
  - lw -> branch: 2 bubbles.
  - ALU -> branch: 1 bubble.
  - ALU -> EX consumer: 0 bubbles (forwarded).

## Timing
- Stall outputs are combinational from the registered cnt[] and the current ID inputs, valid in the same cycle.
- Scoreboard latency: an issue at edge k makes the new count visible from cycle k+1.
- Reset (Reset_n low, asynchronous): all cnt = 0, so the stall outputs are 0 whenever ID_Valid is low or no hazard exists. Stall_Count = 0.
- Reset asserted mid-stall drops all pending state immediately. After release, the first edge starts from an empty scoreboard.
- A stalled instruction re-evaluates every cycle. The stall length is exactly cnt[src] - Slack cycles, with no extra registered delay.
- No cycles are lost on stall release: issue occurs on the same edge hazard falls.

## Configuration
- HAZARD_PERF_EN defined:
  - Stall_Count increments by 1 on every edge where hazard = 1.
  - It saturates at 32'hFFFF_FFFF (no wrap) and clears only on reset.
- HAZARD_PERF_EN undefined:
  - Stall_Count is tied to 0 and no counter register is instantiated.
  - The rest of the behaviour is identical.

## Test plan
- Reset: hold Reset_n low with ID_Valid = 1, ID_rs = 5, ID_UseRs = 1 -> all stall outputs 0, Stall_Count 0. Release -> still 0.
- Load-use:
  - Issue lw with rDest = 8, Latency = 2; next cycle EX-use add with rs = 8 -> stall exactly 1 cycle, then issue.
  - With a branch (EarlyUse = 1) instead of the add -> stall 2 cycles.
- ALU forwarding: issue add with rDest = 3, Latency = 1; next cycle add with rt = 3 -> no stall. Same pair with beq reading $3 -> 1-cycle stall.
- Reg 0 and unused sources:
  - Issue with rDest = 0, Latency = 2; then a reader of rs = 0 -> no stall.
  - A reader of rs = 8 with UseRs = 0 while cnt[8] = 2 -> no stall.
- Flush and WAW:
  - A dependent instruction with Flush_ID = 1 -> no stall and no scoreboard write.
  - Issue Latency 3 to r9, then Latency 1 to r9 -> cnt[9] = 1 and the following EX-use reader does not stall.
- Perf (HAZARD_PERF_EN): three back-to-back 2-cycle branch stalls -> Stall_Count = 6. Preload the count near saturation -> it stays at FFFF_FFFF.
